// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// 8N1 serial receiver with a show-ahead receive FIFO for the CPU UART read port.
// The line is double-flopped into rxs, and a four-state FSM samples each bit
// at its midpoint. Finished bytes go into a FIFO, and the head byte is shown
// on uart0_data.
//
// Optional feature: define UART_RX_FRAME_CHECK_EN to enable stop-bit checking.
//   - A low stop bit pulses frame_err and drops the byte.
//   - The receiver then waits for the line to go high before it accepts a new
//     start bit (break handling).
//   - Without the macro, the stop bit is ignored and frame_err is tied low.
//
// Read handshake (valid/ready style, CPU side):
//   - uart0_valid high means uart0_data holds the oldest unread byte.
//   - uart0_data stays stable until a pop occurs.
//   - A one-cycle uart0_rd pulse while uart0_valid is high consumes that byte
//     at the same clock edge.
//   - uart0_rd while uart0_valid is low is ignored.

module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       uart0_rd,
    output logic       uart0_valid,
    output logic [7:0] uart0_data,
    output logic       frame_err,
    output logic       overrun
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam int HALF_I = CLKS_PER_BIT / 2 - 1;
    localparam int FULL_I = CLKS_PER_BIT - 1;

    localparam logic [CW-1:0] HALF_LOAD = HALF_I[CW-1:0];
    localparam logic [CW-1:0] FULL_LOAD = FULL_I[CW-1:0];
    localparam logic [CW-1:0] CNT_ZERO  = '0;
    localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [AW:0]   DEPTH_L   = FIFO_DEPTH[AW:0];

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic rx_meta;
    logic rxs;

    // Two-flop synchronizer. It resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t         state_q;
    state_t         state_d;
    logic [CW-1:0]  cnt_q;
    logic [CW-1:0]  cnt_d;
    logic [7:0]     shift_q;
    logic [7:0]     shift_d;
    logic [2:0]     bit_q;
    logic [2:0]     bit_d;

    // decide marks the mid-stop-bit edge where the push/drop choice is made.
    logic           decide;

    // stop_good is the stop-bit verdict used by the push rule.
    logic           stop_good;

    // wait_high blocks start detection until the line has gone high again.
    logic           wait_high;

    // FSM state, bit-timing counter, shift register and bit index.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= CNT_ZERO;
            shift_q <= 8'h00;
            bit_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bit_q   <= bit_d;
        end
    end

    // Next-state logic. The counter reloads on every state entry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        decide  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Falling edge seen: wait half a bit to land mid start bit.
                if (!rxs && !wait_high) begin
                    state_d = S_START;
                    cnt_d   = HALF_LOAD;
                end
            end

            S_START: begin
                if (cnt_q == CNT_ZERO) begin
                    if (!rxs) begin
                        state_d = S_DATA;
                        cnt_d   = FULL_LOAD;
                        bit_d   = 3'd0;
                    end else begin
                        // Line went high again before mid start bit: treat as a glitch.
                        state_d = S_IDLE;
                        cnt_d   = CNT_ZERO;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_DATA: begin
                if (cnt_q == CNT_ZERO) begin
                    // LSB arrives first, so each new bit enters at the top.
                    shift_d = {rxs, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_STOP: begin
                if (cnt_q == CNT_ZERO) begin
                    // Leave at mid stop bit so a back-to-back start edge is not missed.
                    decide  = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stop-bit handling
    // ------------------------------------------------------------------
`ifdef UART_RX_FRAME_CHECK_EN
    logic wait_high_q;
    logic frame_err_q;

    assign stop_good = rxs;
    assign wait_high = wait_high_q;
    assign frame_err = frame_err_q;

    // After a low stop bit, hold off start detection until the line is idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_high_q <= 1'b0;
        end else if (decide && !rxs) begin
            wait_high_q <= 1'b1;
        end else if (rxs) begin
            wait_high_q <= 1'b0;
        end
    end

    // One-cycle framing-error pulse, registered at the decision edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= decide && !rxs;
        end
    end
`else
    assign stop_good = 1'b1;
    assign wait_high = 1'b0;
    assign frame_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Receive FIFO
    // ------------------------------------------------------------------
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic        fifo_full;
    logic        fifo_empty;
    logic        pop;
    logic        push_req;
    logic        push;
    logic        drop;
    logic        overrun_q;

    // The extra pointer MSB tells full from empty. Subtraction wraps naturally.
    assign count      = wr_ptr - rd_ptr;
    assign fifo_full  = (count == DEPTH_L);
    assign fifo_empty = (count == '0);

    // A pop on an empty FIFO is ignored. A push is allowed when full only if a
    // pop frees a slot in the same cycle.
    assign pop      = uart0_rd && !fifo_empty;
    assign push_req = decide && stop_good;
    assign push     = push_req && (!fifo_full || pop);
    assign drop     = push_req && fifo_full && !pop;

    // Pointer update. Push and pop may happen in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write. Contents need no reset because outputs are masked when empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= shift_q;
        end
    end

    // One-cycle overrun pulse when a good byte is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= drop;
        end
    end

    assign overrun     = overrun_q;
    assign uart0_valid = !fifo_empty;
    assign uart0_data  = uart0_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo
// Drives 8N1 frames into uart_rx_fifo (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// A frame-level model predicts FIFO contents and status pulses:
//   - the push decision lands at a fixed cycle after the start edge;
//   - the FIFO itself is modelled as a byte queue.
// Outputs are compared on every falling edge, plus literal spot checks.
`timescale 1ns/1ps

module tb_uart_rx_fifo;

  localparam int CPB     = 16;
  localparam int DEPTH   = 4;
  // Cycles from the edge after which rx falls to the stop-bit decision edge:
  //   - 2 synchronizer edges;
  //   - 1 edge for IDLE to see it;
  //   - half a bit to mid start bit;
  //   - 8 data bits plus the stop bit.
  localparam int DEC_OFS = 3 + CPB / 2 + 9 * CPB;

  typedef struct {
    int         dec;
    logic [7:0] data;
    logic       stop;
  } frame_t;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic       uart0_rd = 1'b0;
  logic       uart0_valid;
  logic [7:0] uart0_data;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .uart0_rd   (uart0_rd),
    .uart0_valid(uart0_valid),
    .uart0_data (uart0_data),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  // ---------------- model state ----------------
  frame_t     pend_q[$];
  logic [7:0] exp_q[$];
  logic       exp_fe = 1'b0;
  logic       exp_ov = 1'b0;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         fe_seen = 0;
  int         ov_seen = 0;
  int         next_dec = 0;
  bit         frame_check = 1'b0;
  bit         rand_done = 1'b0;

  // Model: at each rising edge, apply reset, pop and the scheduled push decision.
  initial begin : model
    bit         do_pop;
    bit         push_req;
    logic [7:0] b;
    forever begin
      @(posedge clk);
      cyc++;
      exp_fe = 1'b0;
      exp_ov = 1'b0;
      if (reset) begin
        exp_q.delete();
        pend_q.delete();
      end else begin
        do_pop   = uart0_rd && (exp_q.size() > 0);
        push_req = 1'b0;
        b        = 8'h00;
        if (pend_q.size() > 0 && pend_q[0].dec == cyc) begin
          b = pend_q[0].data;
          if (pend_q[0].stop || !frame_check) push_req = 1'b1;
          else exp_fe = 1'b1;
          void'(pend_q.pop_front());
        end
        if (push_req && exp_q.size() == DEPTH && !do_pop) begin
          exp_ov   = 1'b1;
          push_req = 1'b0;
        end
        if (do_pop) void'(exp_q.pop_front());
        if (push_req) exp_q.push_back(b);
      end
    end
  end

  // Compare: every falling edge, all outputs against the model.
  initial begin : compare
    logic       ev;
    logic [7:0] ed;
    forever begin
      @(negedge clk);
      ev = (exp_q.size() != 0);
      ed = ev ? exp_q[0] : 8'h00;
      n_tests++;
      if (uart0_valid !== ev || uart0_data !== ed || frame_err !== exp_fe || overrun !== exp_ov) begin
        n_fail++;
        if (n_fail <= 20)
          $display("FAIL cycle_check cyc=%0d got valid=%b data=%h fe=%b ov=%b expected valid=%b data=%h fe=%b ov=%b",
                   cyc, uart0_valid, uart0_data, frame_err, overrun, ev, ed, exp_fe, exp_ov);
      end
      if (frame_err === 1'b1) fe_seen++;
      if (overrun === 1'b1) ov_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Must be called 1 time unit after a rising edge.
  task automatic send_byte(input logic [7:0] d, input logic stop);
    frame_t f;
    f.dec  = cyc + DEC_OFS;
    f.data = d;
    f.stop = stop;
    pend_q.push_back(f);
    next_dec = f.dec;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
    rx = 1'b1;
  endtask

  task automatic read_expect(input logic [7:0] d, input string name);
    check({name, "_valid"}, {31'd0, uart0_valid}, 32'd1);
    check({name, "_data"}, {24'd0, uart0_data}, {24'd0, d});
    uart0_rd = 1'b1;
    tick(1);
    uart0_rd = 1'b0;
  endtask

  // Assert uart0_rd so it is sampled at rising edge number c.
  task automatic pop_at(input int c);
    while (cyc < c - 1) tick(1);
    uart0_rd = 1'b1;
    tick(1);
    uart0_rd = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int ov0;
    int fe0;
    int k0;
`ifdef UART_RX_FRAME_CHECK_EN
    frame_check = 1'b1;
`else
    frame_check = 1'b0;
`endif

    // Reset state
    tick(3);
    check("reset_valid", {31'd0, uart0_valid}, 32'd0);
    check("reset_data", {24'd0, uart0_data}, 32'd0);
    check("reset_fe", {31'd0, frame_err}, 32'd0);
    check("reset_ov", {31'd0, overrun}, 32'd0);
    reset = 1'b0;
    tick(4);

    // Single byte
    send_byte(8'hA5, 1'b1);
    read_expect(8'hA5, "single");
    check("single_empty_valid", {31'd0, uart0_valid}, 32'd0);
    check("single_empty_data", {24'd0, uart0_data}, 32'd0);

    // Glitch rejection
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(30);
    check("glitch_valid", {31'd0, uart0_valid}, 32'd0);

    // Overrun
    ov0 = ov_seen;
    for (int b = 1; b <= 5; b++) send_byte(8'(b), 1'b1);
    tick(2);
    check("overrun_count", ov_seen - ov0, 32'd1);
    read_expect(8'h01, "ovr_pop1");
    read_expect(8'h02, "ovr_pop2");
    read_expect(8'h03, "ovr_pop3");
    read_expect(8'h04, "ovr_pop4");
    check("ovr_drained", {31'd0, uart0_valid}, 32'd0);

    // Full FIFO plus a pop in the push cycle
    for (int b = 8'h10; b <= 8'h13; b++) send_byte(8'(b), 1'b1);
    ov0 = ov_seen;
    fork
      send_byte(8'h14, 1'b1);
      begin
        #2;
        pop_at(next_dec);
      end
    join
    tick(2);
    check("fullpop_no_overrun", ov_seen - ov0, 32'd0);
    read_expect(8'h11, "fullpop1");
    read_expect(8'h12, "fullpop2");
    read_expect(8'h13, "fullpop3");
    read_expect(8'h14, "fullpop4");
    check("fullpop_drained", {31'd0, uart0_valid}, 32'd0);

    // Frame error
    fe0 = fe_seen;
    send_byte(8'h3C, 1'b0);
    tick(2 * CPB);
    if (frame_check) begin
      check("ferr_pulses", fe_seen - fe0, 32'd1);
      check("ferr_nothing_pushed", {31'd0, uart0_valid}, 32'd0);
    end else begin
      check("ferr_tied_low", fe_seen - fe0, 32'd0);
      read_expect(8'h3C, "ferr_pushed");
    end
    send_byte(8'h55, 1'b1);
    tick(2);
    read_expect(8'h55, "after_ferr");

    // Reset mid-frame, with a byte already buffered
    send_byte(8'h99, 1'b1);
    fork
      send_byte(8'hFF, 1'b1);
      begin
        #2;
        k0 = next_dec - DEC_OFS;
        while (cyc < k0 + 85) tick(1);
        reset = 1'b1;
        tick(1);
        check("midreset_valid", {31'd0, uart0_valid}, 32'd0);
        check("midreset_data", {24'd0, uart0_data}, 32'd0);
        check("midreset_fe", {31'd0, frame_err}, 32'd0);
        check("midreset_ov", {31'd0, overrun}, 32'd0);
        tick(2);
        reset = 1'b0;
      end
    join
    tick(CPB);
    check("midreset_empty", {31'd0, uart0_valid}, 32'd0);
    send_byte(8'h42, 1'b1);
    read_expect(8'h42, "after_reset");
    check("after_reset_only", {31'd0, uart0_valid}, 32'd0);

    // Randomized frames, gaps and reads
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          tick($urandom_range(0, 24));
          send_byte(8'($urandom_range(0, 255)), 1'b1);
        end
        tick(CPB);
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          uart0_rd = ($urandom_range(0, 5) == 0);
          tick(1);
        end
        uart0_rd = 1'b0;
      end
    join
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (exp_q.size() > 0) begin
        uart0_rd = 1'b1;
        tick(1);
        uart0_rd = 1'b0;
      end
    end
    tick(2);
    check("random_drained", {31'd0, uart0_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial UART receiver with a show-ahead receive FIFO that feeds the J1B CPU's UART read port at I/O address 0x1000. It samples the asynchronous `rx` line, assembles 8N1 frames, and buffers bytes. It presents the head byte on `uart0_data` with `uart0_valid`, which the CPU polls via 0x2000 bit 1. A one-cycle `uart0_rd` pulse from the CPU-side I/O decode consumes the head byte.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per serial bit; 115200 baud at 50 MHz; legal range ≥ 4.
- `FIFO_DEPTH`, 16, receive FIFO entries; power of two, range 2–256.

- `clk` input 1: system clock; single clock domain.
- `reset` input 1: synchronous, active-high reset.
- `rx` input 1: asynchronous serial line, idle high.
- `uart0_rd` input 1: one-cycle pop strobe for the head byte.
- `uart0_valid` output 1: FIFO non-empty.
- `uart0_data` output 8: head byte; 0 when the FIFO is empty.
- `frame_err` output 1: one-cycle pulse when a stop bit is sampled low.
- `overrun` output 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- **Input synchronizer:** two-flop synchronizer on `rx`, reset to 1. All decisions use the synchronized value `rxs`.
- **Bit counter:** width `$clog2(CLKS_PER_BIT)`; it reloads on every state entry.
- **FSM states:** IDLE, START, DATA, STOP.
  - IDLE: when `rxs`==0, go to START and load the counter with `CLKS_PER_BIT/2 - 1` (integer division).
  - START: on counter==0, if `rxs`==0 go to DATA and load `CLKS_PER_BIT-1`. Otherwise treat it as a glitch and return to IDLE.
  - DATA: on each counter==0, shift `rxs` into bit 7 of the shift register, right-shifting so data arrives LSB first. Reload the counter. After the 8th sample go to STOP.
  - STOP: on counter==0, sample the stop bit, apply the push rule, and return to IDLE at mid-stop-bit so back-to-back frames are accepted.
- **Push rule:**
  - If the stop bit is 1: push the byte if not full. If full and no pop in the same cycle, drop the byte and pulse `overrun`.
  - If the stop bit is 0: handled per Configuration.
- **FIFO:**
  - Read and write pointers of width `$clog2(FIFO_DEPTH)+1`; the MSB distinguishes full from empty; pointers wrap naturally.
  - `uart0_valid` = (count != 0).
  - `uart0_data` = `mem[rd_ptr]` when valid, else 0.
- **Simultaneous events:**
  - `uart0_rd` while empty is ignored; pointers are unchanged.
  - Push and pop in the same cycle while full: both accepted, count stays at `FIFO_DEPTH`, no `overrun`.
  - Push and pop in the same cycle while empty: push accepted, pop ignored, count goes to 1.
- **Reset:**
  - Mid-frame, reset aborts the frame and discards the partial byte.
  - FSM goes to IDLE, pointers to 0, synchronizer to 1.

## Timing
- Reset values:
  - `uart0_valid`=0, `uart0_data`=0, `frame_err`=0, `overrun`=0.
  - FSM=IDLE, counter=0, shift register=0.
- Latency, `rx` edge to `rxs`: 2 cycles.
- Latency, stop-bit sample cycle to push: the push is registered at that clock edge; `uart0_valid` rises the cycle after.
- Latency, `uart0_rd` to effect: `uart0_rd` asserted at edge N advances `rd_ptr` at edge N. The next byte (or 0, with `uart0_valid` low) is visible from edge N+1.
- `uart0_data` is stable while `uart0_valid`=1 and no pop occurs, so the CPU's registered I/O read path samples it safely.
- `frame_err` and `overrun` assert for exactly one cycle, coincident with the push-decision edge.
- Minimum frame spacing: full frame time less half a bit.

## Configuration
- `UART_RX_FRAME_CHECK_EN` defined:
  - A stop bit sampled 0 pulses `frame_err`; the byte is discarded.
  - The FSM goes to IDLE and waits for `rxs` high before it can detect a new start bit (break handling).
- Not defined:
  - The stop bit is ignored, the byte is pushed by the normal push rule, and `frame_err` is tied 0.
  - The FSM returns straight to IDLE.

## Test plan
All scenarios use `CLKS_PER_BIT`=16, `FIFO_DEPTH`=4.
- **Single byte:** send 0xA5 (8N1).
  - `uart0_valid` rises; `uart0_data`=0xA5.
  - `uart0_rd` pulse: `uart0_valid`=0 and `uart0_data`=0 on the next cycle.
- **Glitch rejection:** drive `rx` low for 5 cycles, then high.
  - FSM returns to IDLE; no push; `uart0_valid` stays 0.
- **Overrun:** send 0x01–0x05 back-to-back with no reads.
  - FIFO holds 0x01–0x04; `overrun` pulses once on the 5th byte.
  - Four pops return 0x01, 0x02, 0x03, 0x04.
- **Full plus simultaneous pop:** fill with 0x10–0x13, then assert `uart0_rd` in the exact push cycle of 0x14.
  - No `overrun`; subsequent reads return 0x11, 0x12, 0x13, 0x14.
- **Frame error** (macro defined): send 0x3C with stop bit 0.
  - `frame_err` pulses once; nothing pushed.
  - A following 0x55 is received correctly.
  - With the macro undefined, 0x3C is pushed and `frame_err` stays 0.
- **Reset mid-frame:** assert `reset` during data bit 4 of 0xFF, then release and send 0x42.
  - The only byte received is 0x42; all outputs are 0 during reset.
